// File: rtl/regs_sb.sv
// Register file with a write-pending scoreboard: combinational reads, writes/issues land on the next edge, no backpressure.
// Define REGS_SB_BYPASS_EN to forward same-cycle write data (port B first) to the read ports.
module regs_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32,
    parameter int INIT_R1    = 10,
    parameter int INIT_R2    = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
    input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
    output logic [DATA_WIDTH-1:0] o_rd0_data,
    output logic [DATA_WIDTH-1:0] o_rd1_data,
    output logic                  o_rd0_busy,
    output logic                  o_rd1_busy,
    output logic                  o_hazard,
    input  logic                  i_wa_en,
    input  logic [ADDR_WIDTH-1:0] i_wa_addr,
    input  logic [DATA_WIDTH-1:0] i_wa_data,
    input  logic                  i_wb_en,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_iss_en,
    input  logic [ADDR_WIDTH-1:0] i_iss_addr,
    output logic [ADDR_WIDTH:0]   o_busy_cnt
);

    // r0 and anything past the last register are inert aliases of zero.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < 32'(REG_COUNT));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] init_val(input int idx);
        if (idx == 1) return DATA_WIDTH'(INIT_R1);
        if (idx == 2) return DATA_WIDTH'(INIT_R2);
        return '0;
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q;
    logic [ADDR_WIDTH:0]   busy_cnt_d;

    logic wa_ok;
    logic wb_ok;
    logic iss_ok;

    assign wa_ok  = i_wa_en  && addr_ok(i_wa_addr);
    assign wb_ok  = i_wb_en  && addr_ok(i_wb_addr);
    assign iss_ok = i_iss_en && addr_ok(i_iss_addr);

    // Port B is applied last so it wins a same-address collision; issue is applied after the clears.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wa_ok) begin
            regs_d[i_wa_addr] = i_wa_data;
            busy_d[i_wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            regs_d[i_wb_addr] = i_wb_data;
            busy_d[i_wb_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[i_iss_addr] = 1'b1;
        end
        busy_cnt_d = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_WIDTH+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= init_val(i);
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic [1:0]            rd_busy;

    assign rd_addr[0] = i_rd0_addr;
    assign rd_addr[1] = i_rd1_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = addr_ok(rd_addr[p]) ? regs_q[rd_addr[p]] : '0;
            rd_busy[p] = addr_ok(rd_addr[p]) && busy_q[rd_addr[p]];
`ifdef REGS_SB_BYPASS_EN
            if (wb_ok && (i_wb_addr == rd_addr[p])) begin
                rd_data[p] = i_wb_data;
                rd_busy[p] = iss_ok && (i_iss_addr == rd_addr[p]);
            end else if (wa_ok && (i_wa_addr == rd_addr[p])) begin
                rd_data[p] = i_wa_data;
                rd_busy[p] = iss_ok && (i_iss_addr == rd_addr[p]);
            end
`endif
        end
    end

    assign o_rd0_data = rd_data[0];
    assign o_rd1_data = rd_data[1];
    assign o_rd0_busy = rd_busy[0];
    assign o_rd1_busy = rd_busy[1];
    assign o_hazard   = rd_busy[0] | rd_busy[1];
    assign o_busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regs_sb.sv
// Bench for regs_sb: directed scenarios plus randomized traffic against an array-based reference model.
module tb_regs_sb;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int RC = 24;

    logic          i_CLK = 1'b0;
    logic          i_RSTn;
    logic [AW-1:0] i_rd0_addr, i_rd1_addr;
    logic [DW-1:0] o_rd0_data, o_rd1_data;
    logic          o_rd0_busy, o_rd1_busy, o_hazard;
    logic          i_wa_en, i_wb_en, i_iss_en;
    logic [AW-1:0] i_wa_addr, i_wb_addr, i_iss_addr;
    logic [DW-1:0] i_wa_data, i_wb_data;
    logic [AW:0]   o_busy_cnt;

    int checks = 0;
    int errors = 0;

    regs_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .INIT_R1(10), .INIT_R2(5)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn),
        .i_rd0_addr(i_rd0_addr), .i_rd1_addr(i_rd1_addr),
        .o_rd0_data(o_rd0_data), .o_rd1_data(o_rd1_data),
        .o_rd0_busy(o_rd0_busy), .o_rd1_busy(o_rd1_busy), .o_hazard(o_hazard),
        .i_wa_en(i_wa_en), .i_wa_addr(i_wa_addr), .i_wa_data(i_wa_data),
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_iss_en(i_iss_en), .i_iss_addr(i_iss_addr),
        .o_busy_cnt(o_busy_cnt)
    );

    always #5 i_CLK = ~i_CLK;

    // Reference model: the architectural registers and the set of registers awaiting a write.
    logic [DW-1:0] m_regs [RC];
    bit            m_busy [RC];

    function automatic bit ok(input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < RC);
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < RC; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (!ok(a)) return '0;
`ifdef REGS_SB_BYPASS_EN
        if (i_wb_en && ok(i_wb_addr) && i_wb_addr == a) return i_wb_data;
        if (i_wa_en && ok(i_wa_addr) && i_wa_addr == a) return i_wa_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!ok(a)) return 1'b0;
`ifdef REGS_SB_BYPASS_EN
        if ((i_wb_en && ok(i_wb_addr) && i_wb_addr == a) || (i_wa_en && ok(i_wa_addr) && i_wa_addr == a))
            return i_iss_en && ok(i_iss_addr) && i_iss_addr == a;
`endif
        return m_busy[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RC; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_regs[1] = 8'd10;
        m_regs[2] = 8'd5;
    endtask

    task automatic m_step();
        if (i_wa_en && ok(i_wa_addr)) begin m_regs[i_wa_addr] = i_wa_data; m_busy[i_wa_addr] = 0; end
        if (i_wb_en && ok(i_wb_addr)) begin m_regs[i_wb_addr] = i_wb_data; m_busy[i_wb_addr] = 0; end
        if (i_iss_en && ok(i_iss_addr)) m_busy[i_iss_addr] = 1;
    endtask

    task automatic idle();
        i_wa_en = 0; i_wb_en = 0; i_iss_en = 0;
    endtask

    // One clock edge; model follows the same inputs, then enables drop and outputs settle.
    task automatic tick();
        @(posedge i_CLK);
        m_step();
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        i_RSTn = 0; idle();
        i_wa_addr = 0; i_wb_addr = 0; i_iss_addr = 0; i_wa_data = 0; i_wb_data = 0;
        i_rd0_addr = 5'd1; i_rd1_addr = 5'd2;
        m_reset();
        #12;
        checks++; if (o_rd0_data !== 8'd10) begin errors++; $display("FAIL reset_r1: got %0d want 10", o_rd0_data); end
        checks++; if (o_rd1_data !== 8'd5) begin errors++; $display("FAIL reset_r2: got %0d want 5", o_rd1_data); end
        checks++; if (o_busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", o_busy_cnt); end
        checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", o_hazard); end
        @(negedge i_CLK);
        i_RSTn = 1;
        #1;
    endtask

    task automatic test_r0_oob();
        i_wa_en = 1; i_wa_addr = 5'd0; i_wa_data = 8'hFF;
        i_wb_en = 1; i_wb_addr = 5'(RC); i_wb_data = 8'hEE;
        i_iss_en = 1; i_iss_addr = 5'd0;
        i_rd0_addr = 5'd0; i_rd1_addr = 5'(RC);
        tick();
        checks++; if (o_rd0_data !== 8'h00 || o_rd0_busy !== 1'b0) begin errors++; $display("FAIL r0_read: got %h/%b want 00/0", o_rd0_data, o_rd0_busy); end
        checks++; if (o_rd1_data !== 8'h00 || o_rd1_busy !== 1'b0) begin errors++; $display("FAIL oob_read: got %h/%b want 00/0", o_rd1_data, o_rd1_busy); end
        i_iss_en = 1; i_iss_addr = 5'd30;
        tick();
        checks++; if (o_busy_cnt !== 6'd0) begin errors++; $display("FAIL r0_oob_cnt: got %0d want 0", o_busy_cnt); end
    endtask

    task automatic test_same_addr_write();
        i_wa_en = 1; i_wa_addr = 5'd3; i_wa_data = 8'h11;
        i_wb_en = 1; i_wb_addr = 5'd3; i_wb_data = 8'h22;
        tick();
        i_rd0_addr = 5'd3;
        #1;
        checks++; if (o_rd0_data !== 8'h22) begin errors++; $display("FAIL same_addr_b_wins: got %h want 22", o_rd0_data); end
    endtask

    task automatic test_scoreboard();
        i_rd0_addr = 5'd4; i_rd1_addr = 5'd0;
        i_iss_en = 1; i_iss_addr = 5'd4;
        tick();
        checks++; if (o_busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt1: got %0d want 1", o_busy_cnt); end
        checks++; if (o_rd0_busy !== 1'b1 || o_hazard !== 1'b1) begin errors++; $display("FAIL sb_busy_r4: got %b/%b want 1/1", o_rd0_busy, o_hazard); end
        i_iss_en = 1; i_iss_addr = 5'd5;
        tick();
        checks++; if (o_busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_cnt2: got %0d want 2", o_busy_cnt); end
        i_wa_en = 1; i_wa_addr = 5'd4; i_wa_data = 8'h33;
        tick();
        checks++; if (o_busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt3: got %0d want 1", o_busy_cnt); end
        checks++; if (o_rd0_busy !== 1'b0 || o_rd0_data !== 8'h33 || o_hazard !== 1'b0) begin
            errors++; $display("FAIL sb_r4_written: got %b/%h/%b want 0/33/0", o_rd0_busy, o_rd0_data, o_hazard); end
    endtask

    task automatic test_issue_write_same();
        logic [AW:0] cnt_before;
        i_iss_en = 1; i_iss_addr = 5'd6;
        tick();
        cnt_before = o_busy_cnt;
        i_iss_en = 1; i_iss_addr = 5'd6;
        i_wb_en = 1; i_wb_addr = 5'd6; i_wb_data = 8'h44;
        i_rd0_addr = 5'd6;
        tick();
        checks++; if (o_rd0_data !== 8'h44 || o_rd0_busy !== 1'b1) begin errors++; $display("FAIL iss_wr_r6: got %h/%b want 44/1", o_rd0_data, o_rd0_busy); end
        checks++; if (o_busy_cnt !== cnt_before || o_busy_cnt !== 6'(m_cnt())) begin
            errors++; $display("FAIL iss_wr_cnt: got %0d want %0d", o_busy_cnt, m_cnt()); end
    endtask

    task automatic test_bypass_and_reset();
        logic [DW-1:0] want;
        i_rd0_addr = 5'd7;
        i_wb_en = 1; i_wb_addr = 5'd7; i_wb_data = 8'h55;
        #1;
`ifdef REGS_SB_BYPASS_EN
        want = 8'h55;
`else
        want = 8'h00;
`endif
        checks++; if (o_rd0_data !== want) begin errors++; $display("FAIL bypass_read: got %h want %h", o_rd0_data, want); end
        tick();
        checks++; if (o_rd0_data !== 8'h55) begin errors++; $display("FAIL bypass_after: got %h want 55", o_rd0_data); end
        i_iss_en = 1; i_iss_addr = 5'd8;
        tick();
        i_rd0_addr = 5'd1; i_rd1_addr = 5'd8;
        i_wa_en = 1; i_wa_addr = 5'd10; i_wa_data = 8'h66;
        i_iss_en = 1; i_iss_addr = 5'd11;
        #2;
        i_RSTn = 0;
        m_reset();
        #1;
        checks++; if (o_rd0_data !== 8'd10 || o_busy_cnt !== 6'd0 || o_hazard !== 1'b0 || o_rd1_busy !== 1'b0) begin
            errors++; $display("FAIL async_reset: got r1=%0d cnt=%0d hz=%b b8=%b want 10/0/0/0", o_rd0_data, o_busy_cnt, o_hazard, o_rd1_busy); end
        @(posedge i_CLK); #1;
        idle();
        @(negedge i_CLK);
        i_RSTn = 1;
        i_rd0_addr = 5'd10; i_rd1_addr = 5'd7;
        #1;
        checks++; if (o_rd0_data !== 8'h00 || o_rd1_data !== 8'h00 || o_busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_lost_writes: got r10=%h r7=%h cnt=%0d want 00/00/0", o_rd0_data, o_rd1_data, o_busy_cnt); end
        i_wa_en = 1; i_wa_addr = 5'd12; i_wa_data = 8'h5A;
        i_iss_en = 1; i_iss_addr = 5'd13;
        i_rd0_addr = 5'd12; i_rd1_addr = 5'd13;
        tick();
        checks++; if (o_rd0_data !== 8'h5A || o_rd1_busy !== 1'b1 || o_busy_cnt !== 6'd1) begin
            errors++; $display("FAIL post_reset_edge: got %h/%b/%0d want 5A/1/1", o_rd0_data, o_rd1_busy, o_busy_cnt); end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_wa_en = 1'($urandom_range(0, 1)); i_wa_addr = rand_addr(); i_wa_data = DW'($urandom);
            i_wb_en = 1'($urandom_range(0, 1)); i_wb_data = DW'($urandom);
            i_wb_addr = ($urandom_range(0, 3) == 0) ? i_wa_addr : rand_addr();
            i_iss_en = ($urandom_range(0, 2) != 0); i_iss_addr = ($urandom_range(0, 4) == 0) ? i_wb_addr : rand_addr();
            i_rd0_addr = ($urandom_range(0, 2) == 0) ? i_wb_addr : rand_addr();
            i_rd1_addr = ($urandom_range(0, 2) == 0) ? i_wa_addr : rand_addr();
            #1;
            checks++; if (o_rd0_data !== exp_data(i_rd0_addr) || o_rd0_busy !== exp_busy(i_rd0_addr)) begin
                errors++; $display("FAIL rand_rd0 it=%0d a=%0d: got %h/%b want %h/%b", n, i_rd0_addr, o_rd0_data, o_rd0_busy, exp_data(i_rd0_addr), exp_busy(i_rd0_addr)); end
            checks++; if (o_rd1_data !== exp_data(i_rd1_addr) || o_rd1_busy !== exp_busy(i_rd1_addr)) begin
                errors++; $display("FAIL rand_rd1 it=%0d a=%0d: got %h/%b want %h/%b", n, i_rd1_addr, o_rd1_data, o_rd1_busy, exp_data(i_rd1_addr), exp_busy(i_rd1_addr)); end
            checks++; if (o_hazard !== (exp_busy(i_rd0_addr) | exp_busy(i_rd1_addr))) begin
                errors++; $display("FAIL rand_hazard it=%0d: got %b", n, o_hazard); end
            tick();
            checks++; if (o_busy_cnt !== 6'(m_cnt())) begin
                errors++; $display("FAIL rand_cnt it=%0d: got %0d want %0d", n, o_busy_cnt, m_cnt()); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_r0_oob();
        test_same_addr_write();
        test_scoreboard();
        test_issue_write_same();
        test_bypass_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
